// File: rtl/fp32_mul_arb.sv
// Round-robin arbiter feeding one shared single-precision multiplier.
// Pipeline: one operand register stage, then a back-pressurable response stage.

module fp32_mul #(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic [DWIDTH-1:0] result,
   output logic              exception,
   output logic              overflow,
   output logic              underflow
);

   logic        sign;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic [47:0] prod;
   logic        norm, guard, sticky, round_up, zero;
   logic [22:0] frac;
   logic [23:0] frac_r;
   logic [9:0]  exp_u;

   assign sign = a[DWIDTH-1] ^ b[DWIDTH-1];
   assign ea   = a[DWIDTH-2 -: 8];
   assign eb   = b[DWIDTH-2 -: 8];
   assign ma   = {1'b1, a[22:0]};
   assign mb   = {1'b1, b[22:0]};
   assign prod = ma * mb;

   // Product of two [1,2) significands lies in [1,4): bit 47 selects the shift.
   assign norm     = prod[47];
   assign frac     = norm ? prod[46:24] : prod[45:23];
   assign guard    = norm ? prod[23] : prod[22];
   assign sticky   = norm ? |prod[22:0] : |prod[21:0];
   assign round_up = guard & (sticky | frac[0]);
   assign frac_r   = {1'b0, frac} + 24'(round_up);

   // Biased exponent sum carries an extra +127; compared against shifted limits.
   assign exp_u = 10'(ea) + 10'(eb) + 10'(norm) + 10'(frac_r[23]);
   assign zero  = (ea == 8'd0) | (eb == 8'd0);

   always_comb begin
      // NOTE: every output gets a default before the if-chain so no latch is inferred.
      exception = (&ea) | (&eb);
      overflow  = 1'b0;
      underflow = 1'b0;
      result    = {sign, 8'(exp_u - 10'd127), frac_r[22:0]};
      if (exception) begin
         result = '0;
      end else if (zero) begin
         result = {sign, 31'd0};
      end else if (exp_u >= 10'd382) begin
         overflow = 1'b1;
         result   = {sign, 8'hFF, 23'd0};
      end else if (exp_u <= 10'd127) begin
         underflow = 1'b1;
         result    = {sign, 31'd0};
      end
   end

endmodule

module fp32_mul_arb #(
   parameter int NREQ   = 4,
   parameter int IDW    = 2,
   parameter int DWIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DWIDTH-1:0] req_a,
   input  logic [NREQ*DWIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [DWIDTH-1:0]      rsp_result,
   output logic [2:0]             rsp_flags,
   output logic                   busy
);

   logic [IDW-1:0]    ptr, gnt, ptr_next, s1_id;
   logic              gnt_found, accept;
   logic              s1_valid, s1_en, s2_en;
   logic [DWIDTH-1:0] s1_a, s1_b, mul_result;
   logic              mul_exc, mul_ovf, mul_unf;

   assign s2_en  = !rsp_valid | rsp_ready;
   assign s1_en  = !s1_valid | s2_en;
   assign accept = gnt_found & s1_en;
   assign busy   = s1_valid | rsp_valid;

   // Scan offsets from highest to lowest so the nearest requester after ptr wins.
   always_comb begin
      gnt       = '0;
      gnt_found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt       = IDW'((int'(ptr) + k) % NREQ);
            gnt_found = 1'b1;
         end
      end
   end

   assign ptr_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt] = 1'b1;
   end

   fp32_mul #(.DWIDTH(DWIDTH)) u_mul (
      .a         (s1_a),
      .b         (s1_b),
      .result    (mul_result),
      .exception (mul_exc),
      .overflow  (mul_ovf),
      .underflow (mul_unf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset too so the response outputs read 0 out of reset.
         ptr        <= '0;
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_id      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         // NOTE: non-blocking assignments so both stages shift from pre-edge values.
         if (s1_en) begin
            s1_valid <= gnt_found;
            if (gnt_found) begin
               s1_a  <= req_a[int'(gnt) * DWIDTH +: DWIDTH];
               s1_b  <= req_b[int'(gnt) * DWIDTH +: DWIDTH];
               s1_id <= gnt;
               ptr   <= ptr_next;
            end
         end
         if (s2_en) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
               rsp_result <= mul_result;
               rsp_flags  <= {mul_exc, mul_ovf, mul_unf};
               rsp_id     <= s1_id;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp32_mul_arb.sv
// Directed bench for fp32_mul_arb: reset, single request, round robin,
// backpressure, multiplier flags, pointer hold and mid-flight reset.

module tb_fp32_mul_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int DW   = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DW-1:0]   req_a, req_b;
   logic                 rsp_valid, rsp_ready, busy;
   logic [IDW-1:0]       rsp_id;
   logic [DW-1:0]        rsp_result;
   logic [2:0]           rsp_flags;

   int checks = 0;
   int errors = 0;

   logic [31:0] rr_b   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
   logic [31:0] bp_b   [3] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
   logic [31:0] bp_res [3] = '{32'h4040_0000, 32'h4090_0000, 32'h40C0_0000};

   fp32_mul_arb #(.NREQ(NREQ), .IDW(IDW), .DWIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pair(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      // Reset state
      #3;
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
      check("rst_req_ready_idle", 32'(req_ready), 32'h0);
      req_valid = 4'b0001;
      #1;
      check("rst_req_ready_req0", 32'(req_ready), 32'h1);
      req_valid = '0;
      tick();
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // Single request: requester 2, 2.0 x 3.0
      set_pair(2, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b0100;
      #1;
      check("single_req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      #1;
      check("single_s1_rsp_valid", 32'(rsp_valid), 32'h0);
      check("single_s1_busy", 32'(busy), 32'h1);
      tick();
      check("single_rsp_valid", 32'(rsp_valid), 32'h1);
      check("single_rsp_id", 32'(rsp_id), 32'h2);
      check("single_rsp_result", rsp_result, 32'h40C0_0000);
      check("single_rsp_flags", 32'(rsp_flags), 32'h0);
      tick();
      check("single_drain_valid", 32'(rsp_valid), 32'h0);
      check("single_drain_busy", 32'(busy), 32'h0);

      // Round robin from a fresh pointer: requester i computes 1.0 x (i+1).0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_pair(i, 32'h3F80_0000, rr_b[i]);
      for (int c = 0; c < 7; c++) begin
         req_valid = (c < 5) ? 4'b1111 : 4'b0000;
         #1;
         check($sformatf("rr_ready_c%0d", c), 32'(req_ready),
               (c < 5) ? (32'h1 << (c % 4)) : 32'h0);
         if (c >= 2) begin
            check($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
            check($sformatf("rr_rsp_id_c%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
            check($sformatf("rr_rsp_result_c%0d", c), rsp_result, rr_b[(c - 2) % 4]);
         end
         tick();
      end
      check("rr_drain_valid", 32'(rsp_valid), 32'h0);

      // Backpressure: requester 1 streams 1.5 x {2,3,4}, rsp_ready low for 5 cycles
      rsp_ready = 1'b0;
      set_pair(1, 32'h3FC0_0000, bp_b[0]);
      req_valid = 4'b0010;
      #1;
      check("bp_ready_c0", 32'(req_ready), 32'h2);
      tick();
      set_pair(1, 32'h3FC0_0000, bp_b[1]);
      #1;
      check("bp_ready_c1", 32'(req_ready), 32'h2);
      tick();
      set_pair(1, 32'h3FC0_0000, bp_b[2]);
      for (int c = 2; c < 5; c++) begin
         #1;
         check($sformatf("bp_stall_ready_c%0d", c), 32'(req_ready), 32'h0);
         check($sformatf("bp_stall_valid_c%0d", c), 32'(rsp_valid), 32'h1);
         check($sformatf("bp_stall_id_c%0d", c), 32'(rsp_id), 32'h1);
         check($sformatf("bp_stall_result_c%0d", c), rsp_result, bp_res[0]);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'h2);
      check("bp_rsp0_result", rsp_result, bp_res[0]);
      tick();
      req_valid = '0;
      check("bp_rsp1_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp1_result", rsp_result, bp_res[1]);
      tick();
      check("bp_rsp2_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp2_result", rsp_result, bp_res[2]);
      tick();
      check("bp_drain_valid", 32'(rsp_valid), 32'h0);

      // Flags: inf x 1.0, overflow, underflow back to back from requester 3
      set_pair(3, 32'h7F80_0000, 32'h3F80_0000);
      req_valid = 4'b1000;
      #1;
      check("flag_inf_ready", 32'(req_ready), 32'h8);
      tick();
      set_pair(3, 32'h7F00_0000, 32'h7F00_0000);
      #1;
      check("flag_ovf_ready", 32'(req_ready), 32'h8);
      tick();
      set_pair(3, 32'h0080_0000, 32'h0080_0000);
      #1;
      check("flag_unf_ready", 32'(req_ready), 32'h8);
      check("flag_inf_valid", 32'(rsp_valid), 32'h1);
      check("flag_inf_id", 32'(rsp_id), 32'h3);
      check("flag_inf_result", rsp_result, 32'h0);
      check("flag_inf_flags", 32'(rsp_flags), 32'h4);
      tick();
      req_valid = '0;
      check("flag_ovf_bit", 32'(rsp_flags[1]), 32'h1);
      check("flag_ovf_flags", 32'(rsp_flags), 32'h2);
      check("flag_ovf_result", rsp_result, 32'h7F80_0000);
      tick();
      check("flag_unf_flags", 32'(rsp_flags), 32'h1);
      check("flag_unf_result", rsp_result, 32'h0);
      tick();
      check("flag_drain_valid", 32'(rsp_valid), 32'h0);

      // Pointer hold: requester 1 moves ptr to 2, idle, then 0 and 3 together
      set_pair(1, 32'h3F80_0000, 32'h3F80_0000);
      req_valid = 4'b0010;
      #1;
      check("ph_r1_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      check("ph_idle_busy", 32'(busy), 32'h0);
      set_pair(0, 32'h4000_0000, 32'h4000_0000);
      set_pair(3, 32'h4040_0000, 32'h4040_0000);
      req_valid = 4'b1001;
      #1;
      check("ph_first_grant", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0001;
      #1;
      check("ph_second_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      check("ph_rsp_id_first", 32'(rsp_id), 32'h3);
      check("ph_rsp_result_first", rsp_result, 32'h4110_0000);
      tick();
      check("ph_rsp_id_second", 32'(rsp_id), 32'h0);
      check("ph_rsp_result_second", rsp_result, 32'h4080_0000);
      tick();

      // Reset mid-flight with both stages full
      rsp_ready = 1'b0;
      set_pair(2, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b0100;
      #1;
      check("mr_ready_c0", 32'(req_ready), 32'h4);
      tick();
      #1;
      check("mr_ready_c1", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      check("mr_full_valid", 32'(rsp_valid), 32'h1);
      check("mr_full_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mr_rst_valid", 32'(rsp_valid), 32'h0);
      check("mr_rst_busy", 32'(busy), 32'h0);
      check("mr_rst_result", rsp_result, 32'h0);
      tick();
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      tick();
      tick();
      check("mr_no_stale_valid", 32'(rsp_valid), 32'h0);
      check("mr_no_stale_busy", 32'(busy), 32'h0);
      set_pair(1, 32'h3F80_0000, 32'h4000_0000);
      set_pair(3, 32'h3F80_0000, 32'h4040_0000);
      req_valid = 4'b1010;
      #1;
      check("mr_ptr_restart", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      check("mr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("mr_rsp_id", 32'(rsp_id), 32'h1);
      check("mr_rsp_result", rsp_result, 32'h4000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp32_mul_arb.md
# fp32_mul_arb

Round-robin arbiter and two-stage pipeline controller that shares one `fp32_mul` instance among `NREQ` requesters. Each requester offers an operand pair on a valid/ready port. The block grants one pair per cycle, registers it ahead of the combinational multiplier, and registers the product, flags and requester ID into a back-pressurable response stage. It sits between the FPU issue logic and the single multiplier datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, from 2 to 8.
- `IDW`, 2: width of the requester ID; equals clog2(`NREQ`).
- `DWIDTH`, 32: operand and result width; passed to `fp32_mul`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NREQ  bit i: requester i's pair is accepted this cycle. One-hot or zero.
- `req_a`  in  NREQ*DWIDTH  operand A; requester i uses bits [i*DWIDTH +: DWIDTH].
- `req_b`  in  NREQ*DWIDTH  operand B, packed the same way as `req_a`.
- `rsp_valid`  out  1  the response stage holds a result.
- `rsp_ready`  in  1  the consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that issued the result.
- `rsp_result`  out  DWIDTH  `fp32_mul` result.
- `rsp_flags`  out  3  {Exception, Overflow, Underflow} from `fp32_mul`.
- `busy`  out  1  `s1_valid | rsp_valid`.

## Operation
- State:
  - Round-robin pointer `ptr` (IDW bits).
  - Stage 1: `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - Stage 2 (response): `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags`.
- Stage advance:
  - `s2_en = !rsp_valid | rsp_ready`.
  - `s1_en = !s1_valid | s2_en`.
- Grant: combinational. Search `req_valid` starting at index `ptr` and wrap modulo NREQ; the first set bit wins (`gnt`). `req_ready[gnt] = s1_en`; all other bits are 0.
- Accept (`req_valid[gnt] & s1_en`):
  - Stage 1 loads A, B and `gnt`, and `s1_valid` is set to 1.
  - `ptr` becomes `(gnt+1) mod NREQ`.
  - If NREQ is not a power of two, the pointer still wraps at NREQ.
- No accept while `s1_en` is high: `s1_valid` is cleared to 0.
- `ptr` does not change on any cycle without an accept.
- `s2_en` with `s1_valid`: stage 2 loads the `fp32_mul(s1_a, s1_b)` outputs and `s1_id`, and `rsp_valid` is set to 1.
- `s2_en` without `s1_valid`: `rsp_valid` is cleared to 0.
- Stage 2 holds all its values while `rsp_valid & !rsp_ready`. Stage 1 also holds if it is full, and `req_ready` is all zero.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until `req_ready` is seen. `req_ready` depends combinationally on `req_valid` by design. `req_valid` must never depend on `req_ready`.
- The block passes the multiplier's result and flags through unmodified; it does no arithmetic of its own.

## Timing
- Reset, asynchronous, all outputs and state:
  - `ptr` = 0, `s1_valid` = 0, `rsp_valid` = 0.
  - All data registers = 0, so `rsp_id`, `rsp_result` and `rsp_flags` read 0.
  - `busy` = 0. `req_ready` = 0 unless a `req_valid` is high, because with an empty pipeline `s1_en` = 1.
- Latency:
  - Handshake in cycle n gives `rsp_valid` in cycle n+2.
  - Stage 1 is registered at the end of cycle n.
  - The response is registered at the end of cycle n+1.
- Throughput: one result per cycle while `rsp_ready` stays high.
- Backpressure: holding `rsp_ready` low for k ≥ 2 cycles fills both stages. `req_ready` is then 0 until `rsp_ready` returns high. In the cycle `rsp_ready` rises, both stages shift and a new request is accepted in that same cycle.
- Simultaneous requests: exactly one grant per cycle, with no starvation. Each requester with `req_valid` held is served within NREQ accepts.
- Reset asserted mid-operation: in-flight pairs are discarded, `ptr` returns to 0, and no response is produced for them.

## Test plan
- Single request: requester 2 offers A=0x40000000, B=0x40400000 (2.0×3.0) with `rsp_ready`=1 → `req_ready`=4'b0100 in the same cycle; two cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_result`=0x40C00000, `rsp_flags`=0.
- Round robin: all four `req_valid` held high, `rsp_ready`=1 → grants 0,1,2,3,0 on consecutive cycles; `rsp_id` follows the same sequence 2 cycles later; one result per cycle.
- Backpressure: a stream from requester 1 with `rsp_ready` low for 5 cycles → exactly 2 pairs accepted; `req_ready`=0 afterwards; response data stable throughout; no loss or duplication after `rsp_ready` rises.
- Flags: requester 3 offers A=0x7F800000, B=0x3F800000 → `rsp_result`=0, `rsp_flags`=3'b100. A=B=0x7F000000 → `rsp_flags`[1]=1.
- Pointer hold: `ptr`=2, then 3 idle cycles, then requesters 0 and 3 request together → requester 3 is granted first, then requester 0.
- Reset mid-flight: `rst_n` pulsed low with both stages full → `rsp_valid`=0 and `busy`=0 immediately; no stale response after release; the next grant starts from requester 0.
